// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl
//   Initiator-side sequencer for a single-port cache SRAM macro. Accepts burst
//   read/write requests of 1..MAX_BURST consecutive rows and drives the SRAM
//   one row per cycle. Write beats arrive on a valid/ready stream; read beats
//   leave through a one-entry registered, backpressured valid/ready stream.
//
// Ports
//   CLK, nRST                       clock (rising edge), async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_addr, req_len    burst direction, first row, row count
//   wdata, wdata_valid/wdata_ready  write beat stream
//   rdata, rdata_valid/rdata_ready  read beat stream (rdata registered)
//   done                            one-cycle pulse when a burst completes
//   sram_REN/WEN/SEL/wVal/rVal      SRAM macro port
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high
// WRITE | one SRAM write per accepted write beat
// READ  | one SRAM read per cycle whenever the output register can take it
// DRAIN | all rows read; waiting for the last beat to be taken
// DONE  | done pulse; forces an idle gap before the next request

module sram_burst_ctrl #(
    parameter int SRAM_WR_SIZE = 128,
    parameter int SRAM_HEIGHT  = 128,
    parameter int MAX_BURST    = 8,
    localparam int AW = $clog2(SRAM_HEIGHT),
    localparam int LW = $clog2(MAX_BURST) + 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AW-1:0]           req_addr,
    input  logic [LW-1:0]           req_len,
    input  logic [SRAM_WR_SIZE-1:0] wdata,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    output logic [SRAM_WR_SIZE-1:0] rdata,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic                    done,
    output logic                    sram_REN,
    output logic                    sram_WEN,
    output logic [AW:0]             sram_SEL,
    output logic [SRAM_WR_SIZE-1:0] sram_wVal,
    input  logic [SRAM_WR_SIZE-1:0] sram_rVal
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BURST);

    logic [2:0]    state;
    logic [AW-1:0] addr;
    logic [LW-1:0] remaining;
    logic [LW-1:0] len_clamped;
    logic          issue;

    assign len_clamped = (req_len > LEN_MAX) ? LEN_MAX : req_len;

    // A read is issued only when the output register is empty or being
    // emptied this cycle, so a stalled beat is never overwritten.
    assign issue = (state == S_READ) && (!rdata_valid || rdata_ready);

    assign req_ready   = (state == S_IDLE);
    assign wdata_ready = (state == S_WRITE);
    assign done        = (state == S_DONE);
    assign sram_WEN    = (state == S_WRITE) && wdata_valid;
    assign sram_REN    = issue;
    assign sram_SEL    = {1'b0, addr};
    assign sram_wVal   = wdata;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr      <= req_addr;
                        remaining <= len_clamped;
                        if (len_clamped == '0)
                            state <= S_DONE;
                        else if (req_write)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (wdata_valid) begin
                        addr      <= addr + AW'(1);
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1))
                            state <= S_DONE;
                    end
                end
                S_READ: begin
                    // Without an issue the register must be holding a stalled
                    // beat, so there is no handoff-only case to handle here.
                    if (issue) begin
                        rdata       <= sram_rVal;
                        rdata_valid <= 1'b1;
                        addr        <= addr + AW'(1);
                        remaining   <= remaining - LW'(1);
                        if (remaining == LW'(1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!rdata_valid || rdata_ready) begin
                        rdata_valid <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl
//   Directed bench for sram_burst_ctrl with a behavioural SRAM attached.
//   Expected SRAM writes and read beats are queued when a request is issued
//   and checked by a negedge monitor as the DUT produces them.

module tb_sram_burst_ctrl;

    localparam int DW = 128;
    localparam int H  = 128;
    localparam int MB = 8;
    localparam int AW = 7;
    localparam int LW = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [DW-1:0] wdata;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_valid, rdata_ready;
    logic          done;
    logic          sram_REN, sram_WEN;
    logic [AW:0]   sram_SEL;
    logic [DW-1:0] sram_wVal, sram_rVal;

    sram_burst_ctrl #(.SRAM_WR_SIZE(DW), .SRAM_HEIGHT(H), .MAX_BURST(MB)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .done(done),
        .sram_REN(sram_REN), .sram_WEN(sram_WEN), .sram_SEL(sram_SEL),
        .sram_wVal(sram_wVal), .sram_rVal(sram_rVal)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Behavioural SRAM: combinational read, write on rising edge.
    logic [DW-1:0] mem     [H];
    logic [DW-1:0] ref_mem [H];
    always @(posedge CLK) if (sram_WEN) mem[sram_SEL[AW-1:0]] <= sram_wVal;
    assign sram_rVal = mem[sram_SEL[AW-1:0]];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] rd_q   [$];
    logic [AW:0]   wrow_q [$];
    logic [DW-1:0] wdat_q [$];
    int ren_cnt = 0, wen_cnt = 0, done_cnt = 0, beat_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_rdata;

    always @(negedge CLK) begin
        if (!nRST) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_REN) ren_cnt++;
            if (done) done_cnt++;
            if (sram_REN || sram_WEN) begin
                check("ren_wen_exclusive", {127'd0, sram_REN & sram_WEN}, 0);
                check("sel_msb", {127'd0, sram_SEL[AW]}, 0);
            end
            if (sram_WEN) begin
                wen_cnt++;
                check("wen_expected", {127'd0, wrow_q.size() != 0}, 1);
                if (wrow_q.size() != 0) begin
                    check("wen_row", sram_SEL, wrow_q.pop_front());
                    check("wen_data", sram_wVal, wdat_q.pop_front());
                end
            end
            if (prev_stall) check("rdata_hold", rdata, prev_rdata);
            if (rdata_valid && !rdata_ready) check("ren_on_stall", {127'd0, sram_REN}, 0);
            if (rdata_valid && rdata_ready) begin
                beat_cnt++;
                check("rdata_expected", {127'd0, rd_q.size() != 0}, 1);
                if (rd_q.size() != 0) check("rdata", rdata, rd_q.pop_front());
            end
            prev_stall = rdata_valid && !rdata_ready;
            prev_rdata = rdata;
        end
    end

    task automatic wait_accept(output int t0);
        bit ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (req_ready) begin ok = 1; break; end
        end
        @(posedge CLK); #1;
        t0 = cyc;
        req_valid = 1'b0;
        check("req_accept", {127'd0, ok}, 1);
    endtask

    // Returns at the negedge of the done cycle (or after the budget expires).
    task automatic wait_done(input int t0, input int exp_lat, input bit bp);
        bit ok = 0;
        logic [3:0] pat = 4'b1001;
        for (int k = 0; k < 200; k++) begin
            rdata_ready = bp ? pat[3 - (k % 4)] : 1'b1;
            @(negedge CLK);
            if (done) begin
                ok = 1;
                if (exp_lat >= 0) check("done_latency", cyc - t0, exp_lat);
                check("req_ready_in_done", {127'd0, req_ready}, 0);
                break;
            end
            @(posedge CLK); #1;
        end
        check("done_seen", {127'd0, ok}, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d [8],
                            input int gap, input int exp_lat);
        int t0, wen0, dn0;
        wen0 = wen_cnt; dn0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            wrow_q.push_back({1'b0, AW'(a + i)});
            wdat_q.push_back(d[i]);
            ref_mem[AW'(a + i)] = d[i];
        end
        req_write = 1'b1; req_addr = a; req_len = n[LW-1:0]; req_valid = 1'b1;
        wait_accept(t0);
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            if (i > 0) begin
                wdata_valid = 1'b0;
                repeat (gap) begin @(posedge CLK); #1; end
            end
            wdata_valid = 1'b1; wdata = d[i];
            for (int t = 0; t < 20; t++) begin
                @(negedge CLK);
                if (wdata_ready) begin ok = 1; break; end
            end
            @(posedge CLK); #1;
            check("wdata_ready", {127'd0, ok}, 1);
        end
        wdata_valid = 1'b0;
        wait_done(t0, exp_lat, 1'b0);
        @(posedge CLK); #1;
        check("wr_req_ready_back", {127'd0, req_ready}, 1);
        check("wen_count", wen_cnt - wen0, n);
        check("wr_done_count", done_cnt - dn0, 1);
        check("wr_queue_empty", wrow_q.size(), 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int len_req, input int nexp,
                           input bit bp, input int exp_lat);
        int t0, ren0, dn0;
        ren0 = ren_cnt; dn0 = done_cnt;
        for (int i = 0; i < nexp; i++) rd_q.push_back(ref_mem[AW'(a + i)]);
        rdata_ready = 1'b1;
        req_write = 1'b0; req_addr = a; req_len = len_req[LW-1:0]; req_valid = 1'b1;
        wait_accept(t0);
        wait_done(t0, exp_lat, bp);
        @(posedge CLK); #1;
        rdata_ready = 1'b1;
        check("rd_req_ready_back", {127'd0, req_ready}, 1);
        check("ren_count", ren_cnt - ren0, nexp);
        check("rd_done_count", done_cnt - dn0, 1);
        check("rd_queue_empty", rd_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d [8];
        int b0, dn0;
        bit ok;

        for (int i = 0; i < H; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        nRST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata = {4{32'hDEADBEEF}}; wdata_valid = 1'b0; rdata_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        check("rst_req_ready", {127'd0, req_ready}, 1);
        check("rst_wdata_ready", {127'd0, wdata_ready}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rdata_valid", {127'd0, rdata_valid}, 0);
        check("rst_done", {127'd0, done}, 0);
        check("rst_ren", {127'd0, sram_REN}, 0);
        check("rst_wen", {127'd0, sram_WEN}, 0);
        check("rst_sel", sram_SEL, 0);
        check("rst_wval", sram_wVal, wdata);

        // Idle cycles with a stray write beat offered: nothing happens.
        @(posedge CLK); #1;
        wdata_valid = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("idle_wdata_ready", {127'd0, wdata_ready}, 0);
        check("idle_ren", ren_cnt, 0);
        check("idle_wen", wen_cnt, 0);
        wdata_valid = 1'b0;

        // Write then read
        d[0] = 'h11; d[1] = 'h22; d[2] = 'h33; d[3] = 'h44;
        d[4] = '0; d[5] = '0; d[6] = '0; d[7] = '0;
        do_write(7'd5, 4, d, 0, 4);
        do_read(7'd5, 4, 4, 1'b0, 5);

        // Address wrap
        d[0] = 'hA; d[1] = 'hB; d[2] = 'hC; d[3] = 'hD;
        do_write(7'd126, 4, d, 0, 4);
        do_read(7'd126, 4, 4, 1'b0, 5);

        // Backpressured read of a full-length burst
        for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
        do_write(7'd20, 8, d, 0, 8);
        do_read(7'd20, 8, 8, 1'b1, -1);

        // Stalled write, then zero-length requests
        for (int i = 0; i < 8; i++) d[i] = {96'd0, 32'hC0DE_0000 + i};
        do_write(7'd40, 3, d, 2, -1);
        do_read(7'd40, 0, 0, 1'b0, 0);
        do_write(7'd40, 0, d, 0, 0);

        // Over-long request is clamped to MAX_BURST
        do_read(7'd5, 15, 8, 1'b0, 9);

        // Reset in the middle of a read burst
        for (int i = 0; i < 8; i++) rd_q.push_back(ref_mem[AW'(20 + i)]);
        b0 = beat_cnt;
        rdata_ready = 1'b1;
        req_write = 1'b0; req_addr = 7'd20; req_len = 4'd8; req_valid = 1'b1;
        begin int t0; wait_accept(t0); end
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge CLK); #1;
            if (beat_cnt - b0 >= 3) begin ok = 1; break; end
        end
        check("midrst_beats_seen", {127'd0, ok}, 1);
        nRST = 1'b0;
        #1;
        rd_q.delete();
        dn0 = done_cnt;
        check("midrst_rdata_valid", {127'd0, rdata_valid}, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_req_ready", {127'd0, req_ready}, 1);
        check("midrst_ren", {127'd0, sram_REN}, 0);
        check("midrst_done", {127'd0, done}, 0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("midrst_no_done", done_cnt - dn0, 0);
        do_read(7'd126, 2, 2, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
